i281_dmem_preload: RTL and testbench
====================================

Name: i281_dmem_preload

Overview:
- Parametrised i281 data memory that replaces fixed, wire-only DMEM contents with a real register-file memory.
- Powers up and resets to a selectable preset image (bubble sort, linear search, binary search or all-zero).
- CPU side: two asynchronous read ports and one synchronous write port.
- External loader side: valid/ready streaming port, driven by a small FSM, that rewrites the whole array at run time.
- Sits between the i281 datapath/ALU and the visualiser, which reads the flattened contents bus.

Parameters:
- WIDTH, 8: data word width in bits (≥4).
- DEPTH, 16: number of words (power of 2, ≥16).
- AW, log2(DEPTH): address width, derived; not overridable.
- IMAGE, 1: reset image select: 0 = all zero, 1 = bubble sort, 2 = linear search, 3 = binary search.

Ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: asynchronous active-high reset.
- rd_addr_a, in, AW: read port A address.
- rd_data_a, out, WIDTH: mem[rd_addr_a], combinational.
- rd_addr_b, in, AW: read port B address.
- rd_data_b, out, WIDTH: mem[rd_addr_b], combinational.
- wr_en, in, 1: CPU write enable.
- wr_addr, in, AW: CPU write address.
- wr_data, in, WIDTH: CPU write data.
- ld_start, in, 1: request a full-array load.
- ld_valid, in, 1: loader word valid.
- ld_data, in, WIDTH: loader word.
- ld_ready, out, 1: module accepts a loader word this cycle.
- ld_busy, out, 1: load in progress; CPU writes blocked.
- ld_done, out, 1: one-cycle pulse after the last word is written.
- ld_count, out, AW+1: number of words written in the current or last load.
- mem_flat, out, DEPTH*WIDTH: word i at bits [i*WIDTH +: WIDTH], registered contents.

Behaviour:
- Reset (async, any state) loads the IMAGE contents into mem. FSM goes to IDLE; ld_ready=0, ld_busy=0, ld_done=0, ld_count=0.
- Preset images, listed from address 0. Values are zero-extended to WIDTH; unlisted addresses are 0; entries at index ≥ DEPTH are dropped.
  - IMAGE 1: 7,6,5,4,3.
  - IMAGE 2: 5,2,7,3,6,1,0,0,8,6.
  - IMAGE 3: 1,2,4,5,7,8,9,0,0,6,0,5.
  - IMAGE 0 or any other value: all zero.
- Reads: combinational, zero latency. A write becomes visible on the read ports and mem_flat immediately after the clock edge that performs it. A read of an address being written in the same cycle returns the old value.
- CPU write: when wr_en=1 and FSM is IDLE, mem[wr_addr] <= wr_data at the rising edge. wr_en is ignored in LOAD and DONE.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: ld_start=1 -> LOAD; ptr <= 0; ld_count <= 0. If ld_start and wr_en are asserted in the same cycle, the CPU write still commits that edge.
  - LOAD: ld_ready=1, ld_busy=1. On each ld_valid & ld_ready: mem[ptr] <= ld_data, ptr++, ld_count++. If ld_valid=0, the FSM holds with no write (gaps allowed). ld_start is ignored. When the word at ptr = DEPTH-1 is accepted -> DONE.
  - DONE: ld_done=1 and ld_busy=1 for exactly one cycle; ld_ready=0; then -> IDLE. ld_count holds DEPTH until the next ld_start.
- Load latency: DEPTH accepted words plus 1 cycle in DONE; minimum DEPTH+2 cycles from ld_start to returning to IDLE.
- ptr is AW bits wide and never wraps within a load; ld_count saturates at DEPTH.
- Reset mid-load: the partial load is discarded, the full image is restored, and ld_done is not pulsed.
- ld_valid outside LOAD is ignored.

Test Plan:
- Reset with IMAGE=1, WIDTH=8, DEPTH=16 -> mem_flat[39:0]=0x0304050607; all other words 0; rd_addr_a=2 gives rd_data_a=0x05.
- CPU write wr_addr=5, wr_data=0xA5 with rd_addr_b=5 in the same cycle -> rd_data_b=0x00 that cycle, 0xA5 the next.
- ld_start, then 16 words 0x10..0x1F with ld_valid deasserted every third cycle -> mem[i]=0x10+i; ld_done pulses once; ld_count=16; a wr_en asserted mid-load changes nothing.
- Reset asserted after 7 loader words -> mem equals the IMAGE preset, FSM is IDLE, ld_busy=0, ld_done never pulses.
- IMAGE=3, WIDTH=16, DEPTH=32 -> word 11=0x0005, word 9=0x0006, words 12..31 = 0; full load of 32 words completes with ld_count=32.
- IMAGE=2 with DEPTH=16 -> word 8=8, word 9=6; ld_start and wr_en to address 3 with value 0x44 in the same IDLE cycle -> mem[3]=0x44, then the load proceeds and overwrites mem[3].

Source files
------------

// File: rtl/i281_dmem_preload.sv
// ============================================================================
// Module   : i281_dmem_preload
// Purpose  : i281 data memory with preset reset images, two async read ports,
//            one sync CPU write port and a streaming full-array loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i281_dmem_preload #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    parameter  int IMAGE = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [AW-1:0]          rd_addr_a,
    output logic [WIDTH-1:0]       rd_data_a,
    input  logic [AW-1:0]          rd_addr_b,
    output logic [WIDTH-1:0]       rd_data_b,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    input  logic [WIDTH-1:0]       ld_data,
    output logic                   ld_ready,
    output logic                   ld_busy,
    output logic                   ld_done,
    output logic [AW:0]            ld_count,
    output logic [DEPTH*WIDTH-1:0] mem_flat
);

    localparam logic [AW-1:0] C_LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW:0]   C_CNT_MAX  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [AW:0]       ld_count_q, ld_count_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    // Preset program data; indices past DEPTH are never requested, so
    // oversize entries drop out naturally on small memories.
    function automatic logic [WIDTH-1:0] image_word(input int idx);
        int v;
        v = 0;
        case (IMAGE)
            1: case (idx)
                0: v = 7;  1: v = 6;  2: v = 5;  3: v = 4;  4: v = 3;
                default: v = 0;
            endcase
            2: case (idx)
                0: v = 5;  1: v = 2;  2: v = 7;  3: v = 3;  4: v = 6;
                5: v = 1;  8: v = 8;  9: v = 6;
                default: v = 0;
            endcase
            3: case (idx)
                0: v = 1;  1: v = 2;  2: v = 4;  3: v = 5;  4: v = 7;
                5: v = 8;  6: v = 9;  9: v = 6;  11: v = 5;
                default: v = 0;
            endcase
            default: v = 0;
        endcase
        return WIDTH'(v);
    endfunction

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ld_count_d = ld_count_q;
        mem_d      = mem_q;
        ld_ready   = 1'b0;
        ld_busy    = 1'b0;
        ld_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A CPU write coinciding with ld_start still commits.
                if (wr_en) begin
                    mem_d[wr_addr] = wr_data;
                end
                if (ld_start) begin
                    state_d    = S_LOAD;
                    ptr_d      = '0;
                    ld_count_d = '0;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                ld_busy  = 1'b1;
                if (ld_valid) begin
                    mem_d[ptr_q] = ld_data;
                    ptr_d        = ptr_q + AW'(1);
                    if (ld_count_q != C_CNT_MAX) begin
                        ld_count_d = ld_count_q + (AW + 1)'(1);
                    end
                    if (ptr_q == C_LAST_PTR) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                ld_busy = 1'b1;
                ld_done = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            ld_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= image_word(i);
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ld_count_q <= ld_count_d;
            mem_q      <= mem_d;
        end
    end

    assign rd_data_a = mem_q[rd_addr_a];
    assign rd_data_b = mem_q[rd_addr_b];
    assign ld_count  = ld_count_q;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_flat
            assign mem_flat[i*WIDTH +: WIDTH] = mem_q[i];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_i281_dmem_preload.sv
// ============================================================================
// Module   : tb_i281_dmem_preload
// Purpose  : Scoreboard bench for i281_dmem_preload across three configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i281_dmem_preload;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [4:0]  ra [3];
    logic [4:0]  rb [3];
    logic [4:0]  wa [3];
    logic [15:0] wd [3];
    logic [15:0] ldd[3];
    logic        we [3];
    logic        ls [3];
    logic        lv [3];

    logic [7:0]   d0_rda, d0_rdb, d2_rda, d2_rdb;
    logic [15:0]  d1_rda, d1_rdb;
    logic         d0_rdy, d0_busy, d0_done;
    logic         d1_rdy, d1_busy, d1_done;
    logic         d2_rdy, d2_busy, d2_done;
    logic [4:0]   d0_cnt, d2_cnt;
    logic [5:0]   d1_cnt;
    logic [127:0] d0_flat, d2_flat;
    logic [511:0] d1_flat;

    i281_dmem_preload #(.WIDTH(8), .DEPTH(16), .IMAGE(1)) u_d0 (
        .clock(clock), .reset(reset),
        .rd_addr_a(ra[0][3:0]), .rd_data_a(d0_rda),
        .rd_addr_b(rb[0][3:0]), .rd_data_b(d0_rdb),
        .wr_en(we[0]), .wr_addr(wa[0][3:0]), .wr_data(wd[0][7:0]),
        .ld_start(ls[0]), .ld_valid(lv[0]), .ld_data(ldd[0][7:0]),
        .ld_ready(d0_rdy), .ld_busy(d0_busy), .ld_done(d0_done),
        .ld_count(d0_cnt), .mem_flat(d0_flat)
    );

    i281_dmem_preload #(.WIDTH(16), .DEPTH(32), .IMAGE(3)) u_d1 (
        .clock(clock), .reset(reset),
        .rd_addr_a(ra[1]), .rd_data_a(d1_rda),
        .rd_addr_b(rb[1]), .rd_data_b(d1_rdb),
        .wr_en(we[1]), .wr_addr(wa[1]), .wr_data(wd[1]),
        .ld_start(ls[1]), .ld_valid(lv[1]), .ld_data(ldd[1]),
        .ld_ready(d1_rdy), .ld_busy(d1_busy), .ld_done(d1_done),
        .ld_count(d1_cnt), .mem_flat(d1_flat)
    );

    i281_dmem_preload #(.WIDTH(8), .DEPTH(16), .IMAGE(2)) u_d2 (
        .clock(clock), .reset(reset),
        .rd_addr_a(ra[2][3:0]), .rd_data_a(d2_rda),
        .rd_addr_b(rb[2][3:0]), .rd_data_b(d2_rdb),
        .wr_en(we[2]), .wr_addr(wa[2][3:0]), .wr_data(wd[2][7:0]),
        .ld_start(ls[2]), .ld_valid(lv[2]), .ld_data(ldd[2][7:0]),
        .ld_ready(d2_rdy), .ld_busy(d2_busy), .ld_done(d2_done),
        .ld_count(d2_cnt), .mem_flat(d2_flat)
    );

    // Preset lists exactly as the i281 programs define them.
    int img1[5]  = '{7, 6, 5, 4, 3};
    int img2[10] = '{5, 2, 7, 3, 6, 1, 0, 0, 8, 6};
    int img3[12] = '{1, 2, 4, 5, 7, 8, 9, 0, 0, 6, 0, 5};

    function automatic int depth_of(input int d); return (d == 1) ? 32 : 16; endfunction
    function automatic int width_of(input int d); return (d == 1) ? 16 : 8;  endfunction
    function automatic int img_of(input int d);   return (d == 0) ? 1 : ((d == 1) ? 3 : 2); endfunction
    function automatic logic [15:0] msk(input int d); return (d == 1) ? 16'hFFFF : 16'h00FF; endfunction

    function automatic int img_val(input int img, input int idx);
        case (img)
            1: return (idx < 5)  ? img1[idx] : 0;
            2: return (idx < 10) ? img2[idx] : 0;
            3: return (idx < 12) ? img3[idx] : 0;
            default: return 0;
        endcase
    endfunction

    // Reference model: memory contents plus load progress per instance.
    logic [15:0] mm [3][32];
    int          ph [3];   // 0 idle, 1 loading, 2 done-pulse cycle
    int          ptr[3];
    int          cnt[3];

    typedef struct {
        int           d;
        int           k;
        logic [511:0] exp;
    } item_t;
    item_t q[$];
    string kname[7] = '{"rd_data_a", "rd_data_b", "ld_ready", "ld_busy",
                        "ld_done", "ld_count", "mem_flat"};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 32; i++) begin
                mm[d][i] = (i < depth_of(d)) ? 16'(img_val(img_of(d), i)) & msk(d) : 16'h0;
            end
            ph[d] = 0; ptr[d] = 0; cnt[d] = 0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            case (ph[d])
                0: begin
                    if (we[d]) mm[d][int'(wa[d]) % depth_of(d)] = wd[d] & msk(d);
                    if (ls[d]) begin ph[d] = 1; ptr[d] = 0; cnt[d] = 0; end
                end
                1: begin
                    if (lv[d]) begin
                        mm[d][ptr[d]] = ldd[d] & msk(d);
                        ptr[d]++;
                        cnt[d]++;
                        if (ptr[d] == depth_of(d)) ph[d] = 2;
                    end
                end
                default: ph[d] = 0;
            endcase
        end
    endtask

    function automatic logic [511:0] flat_model(input int d);
        logic [511:0] f = '0;
        for (int i = 0; i < depth_of(d); i++) f |= 512'(mm[d][i]) << (i * width_of(d));
        return f;
    endfunction

    function automatic logic [511:0] flat_image(input int d);
        logic [511:0] f = '0;
        logic [15:0]  v;
        for (int i = 0; i < depth_of(d); i++) begin
            v = 16'(img_val(img_of(d), i)) & msk(d);
            f |= 512'(v) << (i * width_of(d));
        end
        return f;
    endfunction

    function automatic logic [511:0] flat_ramp(input int d);
        logic [511:0] f = '0;
        logic [15:0]  v;
        for (int i = 0; i < depth_of(d); i++) begin
            v = 16'(16'h10 + i) & msk(d);
            f |= 512'(v) << (i * width_of(d));
        end
        return f;
    endfunction

    task automatic push(input int d, input int k, input logic [511:0] exp);
        item_t it;
        it.d = d; it.k = k; it.exp = exp;
        q.push_back(it);
    endtask

    task automatic push_cycle();
        for (int d = 0; d < 3; d++) begin
            push(d, 0, 512'(mm[d][int'(ra[d]) % depth_of(d)]));
            push(d, 1, 512'(mm[d][int'(rb[d]) % depth_of(d)]));
            push(d, 2, 512'(ph[d] == 1));
            push(d, 3, 512'(ph[d] != 0));
            push(d, 4, 512'(ph[d] == 2));
            push(d, 5, 512'(cnt[d]));
            push(d, 6, flat_model(d));
        end
    endtask

    function automatic logic [511:0] get_actual(input int d, input int k);
        logic [511:0] a = '0;
        case (d)
            0: case (k)
                0: a = 512'(d0_rda); 1: a = 512'(d0_rdb); 2: a = 512'(d0_rdy);
                3: a = 512'(d0_busy); 4: a = 512'(d0_done); 5: a = 512'(d0_cnt);
                default: a = 512'(d0_flat);
            endcase
            1: case (k)
                0: a = 512'(d1_rda); 1: a = 512'(d1_rdb); 2: a = 512'(d1_rdy);
                3: a = 512'(d1_busy); 4: a = 512'(d1_done); 5: a = 512'(d1_cnt);
                default: a = d1_flat;
            endcase
            default: case (k)
                0: a = 512'(d2_rda); 1: a = 512'(d2_rdb); 2: a = 512'(d2_rdy);
                3: a = 512'(d2_busy); 4: a = 512'(d2_done); 5: a = 512'(d2_cnt);
                default: a = 512'(d2_flat);
            endcase
        endcase
        return a;
    endfunction

    // Monitor: outputs are settled mid-cycle; drain everything queued.
    always @(negedge clock) begin
        while (q.size() > 0) begin
            item_t        it;
            logic [511:0] act;
            it  = q.pop_front();
            act = get_actual(it.d, it.k);
            n_tests++;
            if (act !== it.exp) begin
                n_fail++;
                $display("FAIL dut%0d %s: got %0h expected %0h", it.d, kname[it.k], act, it.exp);
            end
        end
    end

    task automatic check_reset_state(input int d);
        logic [511:0] act;
        for (int k = 2; k <= 5; k++) begin
            act = get_actual(d, k);
            n_tests++;
            if (act !== 512'h0) begin
                n_fail++;
                $display("FAIL dut%0d reset state %s: got %0h expected 0", d, kname[k], act);
            end
        end
    endtask

    task automatic cycle();
        if (reset) model_reset();
        push_cycle();
        @(posedge clock);
        if (reset) model_reset(); else model_step();
        #1;
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 3; d++) begin
            ra[d] = 5'($urandom_range(0, depth_of(d) - 1));
            rb[d] = 5'($urandom_range(0, depth_of(d) - 1));
            wa[d] = 5'($urandom_range(0, depth_of(d) - 1));
            wd[d] = 16'($urandom); ldd[d] = 16'($urandom);
            we[d] = 1'b0; ls[d] = 1'b0; lv[d] = 1'b0;
        end
    endtask

    task automatic do_load(input int d, input int rst_after, input bit cpu_same);
        int waited;
        bit was_reset;
        waited    = 0;
        was_reset = 1'b0;
        idle_inputs();
        ls[d] = 1'b1;
        if (cpu_same) begin we[d] = 1'b1; wa[d] = 5'd3; wd[d] = 16'h44; end
        cycle();
        if (cpu_same) begin
            idle_inputs();
            ra[d] = 5'd3;
            push(d, 0, 512'h44);
        end
        for (int c = 0; c < 400 && ph[d] != 0; c++) begin
            if (!cpu_same || c > 0) idle_inputs();
            lv[d]  = ((c % 3) != 2);
            ldd[d] = 16'(16'h10 + ptr[d]);
            we[d]  = 1'($urandom_range(0, 1));
            ls[d]  = 1'($urandom_range(0, 1));
            if (rst_after >= 0 && cnt[d] == rst_after) reset = 1'b1;
            cycle();
            waited++;
            if (reset) begin
                check_reset_state(d);
                was_reset = 1'b1;
                reset = 1'b0;
                break;
            end
        end
        n_tests++;
        if (!was_reset && waited >= 400) begin
            n_fail++;
            $display("FAIL dut%0d load did not return to IDLE within %0d cycles", d, waited);
        end
        idle_inputs();
        if (rst_after >= 0) begin
            push(d, 6, flat_image(d));
        end else begin
            push(d, 6, flat_ramp(d));
            push(d, 5, 512'(depth_of(d)));
        end
        push(d, 3, 512'h0);
        cycle();
    endtask

    initial begin
        idle_inputs();
        @(posedge clock);
        #1;
        cycle();
        cycle();
        for (int d = 0; d < 3; d++) check_reset_state(d);
        reset = 1'b0;

        // Preset images straight out of reset.
        idle_inputs();
        ra[0] = 5'd2;  push(0, 0, 512'h05);
        push(0, 6, 512'h0304050607);
        ra[1] = 5'd11; push(1, 0, 512'h0005);
        rb[1] = 5'd9;  push(1, 1, 512'h0006);
        ra[2] = 5'd8;  push(2, 0, 512'h08);
        rb[2] = 5'd9;  push(2, 1, 512'h06);
        cycle();

        // Write-then-read: old value in the write cycle, new one after.
        idle_inputs();
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 16'h00A5; rb[0] = 5'd5;
        push(0, 1, 512'h00);
        cycle();
        idle_inputs();
        rb[0] = 5'd5;
        push(0, 1, 512'hA5);
        cycle();

        // Random CPU traffic; stray ld_valid must be ignored while idle.
        for (int c = 0; c < 60; c++) begin
            idle_inputs();
            for (int d = 0; d < 3; d++) begin
                we[d] = 1'($urandom_range(0, 1));
                lv[d] = 1'($urandom_range(0, 1));
            end
            cycle();
        end

        do_load(0, -1, 1'b0);
        do_load(0, 7, 1'b0);
        do_load(1, -1, 1'b0);
        do_load(2, -1, 1'b1);

        // Fully random traffic including overlapping loads and resets.
        for (int c = 0; c < 400; c++) begin
            idle_inputs();
            for (int d = 0; d < 3; d++) begin
                we[d] = 1'($urandom_range(0, 1));
                lv[d] = ($urandom_range(0, 3) != 0);
                ls[d] = ($urandom_range(0, 15) == 0);
            end
            reset = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;
        idle_inputs();
        cycle();
        cycle();

        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
